drum_pipe_mult: RTL and testbench
=================================

DRUM_PIPE_MULT -- requirements
Module: drum_pipe_mult

Interface
REQ-001 SHALL have parameter N, default 16: width of operand a.
REQ-002 SHALL have parameter M, default 16: width of operand b.
REQ-003 SHALL have parameter KMAX, default 8: widest truncated mantissa, legal 3..min(N,M).
REQ-004 SHALL have parameter TW, default 4: width of the pass-through tag.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: operand transaction offered.
REQ-008 SHALL have port in_ready, output, 1: transaction accepted when in_valid && in_ready.
REQ-009 SHALL have port a, input, N: multiplicand.
REQ-010 SHALL have port b, input, M: multiplier.
REQ-011 SHALL have port k_sel, input, $clog2(KMAX+1): runtime mantissa width K.
REQ-012 SHALL have port signed_mode, input, 1: 1 = two's-complement operands and result, 0 = unsigned.
REQ-013 SHALL have port in_tag, input, TW: opaque tag carried with the transaction.
REQ-014 SHALL have port out_valid, output, 1: result present.
REQ-015 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-016 SHALL have port r, output, N+M: approximate product.
REQ-017 SHALL have port out_tag, output, TW: tag of the transaction in r.

Function
REQ-018 SHALL sample a, b, k_sel, signed_mode and in_tag together on acceptance and use only those values for that transaction.
REQ-019 SHALL clamp K: k_sel<3 -> 3, k_sel>KMAX -> KMAX.
REQ-020 SHALL, when signed_mode=1, use |x| as magnitude (most-negative value -> 2^(W-1), unsigned); when 0, use x unchanged.
REQ-021 SHALL per operand: j = index of leading one of the magnitude (0 if magnitude 0); if j<=K-1, mantissa = magnitude[K-1:0] and shift 0; otherwise mantissa = {1, magnitude[j-1:j-K+2], 1} (K bits) and shift = j-K+1.
REQ-022 SHALL compute r = (mant_a*mant_b) << (shift_a+shift_b), zero-extended to N+M.
REQ-023 SHALL, in signed mode, negate r when operand signs differ and magnitude is nonzero; no overflow is possible for K>=3.
REQ-024 SHALL be a 3-stage pipeline (S1 encode/truncate, S2 mantissa multiply, S3 shift/sign-restore); latency exactly 3 cycles from acceptance to out_valid with no stall.
REQ-025 SHALL sustain one transaction per cycle when out_ready=1.
REQ-026 SHALL advance each stage when the downstream stage is empty or advancing; in_ready = !S1_valid || S1 advancing (bubbles collapse).
REQ-027 SHALL hold r, out_tag and out_valid stable while out_valid && !out_ready.
REQ-028 SHALL deliver results in acceptance order, never dropping or duplicating one.
REQ-029 SHALL accept a new input and retire an output in the same cycle when both handshakes fire.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear all stage valid flags and drive out_valid=0, r=0, out_tag=0, in_ready=0 during reset.
REQ-031 SHALL discard all in-flight transactions on reset mid-operation; in_ready=1 the first cycle after rst deasserts.

Structure
REQ-032 SHALL place KMIN=3, LAT=3 and the K-clamp function in shared package drum_pkg.
REQ-033 SHALL implement REQ-020/021 in one sub-module drum_operand_encode (parameters W, KMAX), instantiated once per operand.

Verification (N=M=16, KMAX=8)
REQ-034 SHALL check unsigned a=1000, b=1000, k_sel=6 -> r=1016064; k_sel=8 -> 1008016; k_sel=2 (clamped to 3) -> 802816.
REQ-035 SHALL check a=13, b=11, k_sel=6 -> exact r=143; a=0, b=1000 -> r=0.
REQ-036 SHALL check signed_mode=1, a=-1000, b=1000, k_sel=6 -> r=-1016064; a=-1000, b=-1000 -> r=1016064.
REQ-037 SHALL check back-to-back 10 transactions with out_ready=1 -> first out_valid 3 cycles after first accept, then one result per cycle, tags in order.
REQ-038 SHALL check out_ready=0 for 6 cycles with in_valid=1 -> exactly 3 accepted then in_ready=0; on release, all results emerge in order, none lost.
REQ-039 SHALL check rst pulsed with 2 transactions in flight -> out_valid=0 next cycle, neither result ever appears, in_ready=1 after deassert.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared constants and helpers for the DRUM approximate multiplier.
//   KMIN    : narrowest truncated mantissa the datapath will use
//   LAT     : cycles from input acceptance to out_valid with no stall
//   clamp_k : maps a raw runtime mantissa request onto [KMIN, kmax]
package drum_pkg;

    localparam int KMIN = 3;
    localparam int LAT  = 3;

    function automatic int clamp_k(input int k_req, input int kmax);
        if (k_req < KMIN) begin
            return KMIN;
        end
        if (k_req > kmax) begin
            return kmax;
        end
        return k_req;
    endfunction

endpackage

// File: rtl/drum_operand_encode.sv
// Purely combinational DRUM operand encoder (one instance per operand).
// Takes an operand, derives its magnitude (two's complement when signed_mode),
// finds the leading one and produces a K-bit mantissa plus the left shift
// that restores its weight.
//   x           : W-bit operand
//   signed_mode : 1 = x is two's complement, 0 = unsigned
//   k           : effective mantissa width, already clamped to [3, KMAX]
//   mant        : truncated mantissa, zero-extended to KMAX bits
//   shift       : weight of the mantissa LSB
//   sign        : operand is negative (only ever set in signed mode)
module drum_operand_encode #(
    parameter int W    = 16,
    parameter int KMAX = 8
) (
    input  logic [W-1:0]                x,
    input  logic                        signed_mode,
    input  logic [$clog2(KMAX+1)-1:0]   k,
    output logic [KMAX-1:0]             mant,
    output logic [$clog2(W)-1:0]        shift,
    output logic                        sign
);

    localparam int LW = $clog2(W);

    logic [W-1:0] mag;
    int           lead_i;
    int           k_i;

    always_comb begin
        sign   = signed_mode & x[W-1];
        // The most negative value wraps back onto itself, which read as
        // unsigned is exactly 2^(W-1) -- the magnitude we want.
        mag    = sign ? (~x + W'(1)) : x;
        k_i    = int'(k);

        // Highest set bit wins because later iterations overwrite.
        lead_i = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) begin
                lead_i = i;
            end
        end

        if (lead_i <= k_i - 1) begin
            // Small operand: represented exactly, bits above K-1 are zero.
            mant  = mag[KMAX-1:0];
            shift = '0;
        end else begin
            // Keep the leading one and the next K-2 bits, then force the
            // LSB to one: that stands in for the expected value of the
            // discarded tail and makes the error unbiased.
            shift = LW'(lead_i - k_i + 1);
            mant  = KMAX'(mag >> shift) | KMAX'(1);
        end
    end

endmodule

// File: rtl/drum_pipe_mult.sv
// Three-stage pipelined DRUM approximate multiplier with valid/ready
// handshakes on both sides and an opaque tag carried alongside each result.
//   S1 : encode both operands (combinational) and register mantissas/shifts
//   S2 : K x K mantissa multiply
//   S3 : restore weight by shifting, negate when the signs differ
// Ports:
//   clk, rst                 : single clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake
//   a, b, k_sel, signed_mode : operands, requested mantissa width, mode
//   in_tag / out_tag         : tag travelling with the transaction
//   out_valid/out_ready      : output handshake
//   r                        : approximate N+M bit product
module drum_pipe_mult
    import drum_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 16,
    parameter int KMAX = 8,
    parameter int TW   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               a,
    input  logic [M-1:0]               b,
    input  logic [$clog2(KMAX+1)-1:0]  k_sel,
    input  logic                       signed_mode,
    input  logic [TW-1:0]              in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N+M-1:0]             r,
    output logic [TW-1:0]              out_tag
);

    localparam int KW = $clog2(KMAX+1);
    localparam int SA = $clog2(N);
    localparam int SB = $clog2(M);
    localparam int SW = $clog2(N+M);
    localparam int PW = 2*KMAX;
    localparam int RW = N+M;

    // Operand encoding, feeding the S1 register.
    logic [KW-1:0]   k_eff;
    logic [KMAX-1:0] mant_a, mant_b;
    logic [SA-1:0]   shift_a;
    logic [SB-1:0]   shift_b;
    logic            sign_a, sign_b;

    assign k_eff = KW'(clamp_k(int'(k_sel), KMAX));

    drum_operand_encode #(.W(N), .KMAX(KMAX)) u_enc_a (
        .x           (a),
        .signed_mode (signed_mode),
        .k           (k_eff),
        .mant        (mant_a),
        .shift       (shift_a),
        .sign        (sign_a)
    );

    drum_operand_encode #(.W(M), .KMAX(KMAX)) u_enc_b (
        .x           (b),
        .signed_mode (signed_mode),
        .k           (k_eff),
        .mant        (mant_b),
        .shift       (shift_b),
        .sign        (sign_b)
    );

    // Pipeline registers.
    logic            s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [KMAX-1:0] s1_mant_a_reg, s1_mant_b_reg;
    logic [SW-1:0]   s1_shift_reg, s2_shift_reg;
    logic            s1_neg_reg, s2_neg_reg;
    logic [TW-1:0]   s1_tag_reg, s2_tag_reg, s3_tag_reg;
    logic [PW-1:0]   s2_prod_reg;
    logic [RW-1:0]   s3_r_reg;

    // A stage can take new data when it is empty or its content is leaving
    // this cycle; chaining these lets bubbles collapse under backpressure.
    logic s1_ready, s2_ready, s3_ready;

    assign s3_ready = !s3_valid_reg || out_ready;
    assign s2_ready = !s2_valid_reg || s3_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;
    assign in_ready = !rst && s1_ready;

    logic [SW-1:0] shift_sum_next;
    logic [PW-1:0] prod_next;
    logic [RW-1:0] shifted;
    logic [RW-1:0] res_next;

    always_comb begin
        shift_sum_next = SW'(shift_a) + SW'(shift_b);
        prod_next      = PW'(s1_mant_a_reg) * PW'(s1_mant_b_reg);
        shifted        = RW'(s2_prod_reg) << s2_shift_reg;
        res_next       = shifted;
        if (s2_neg_reg && (shifted != '0)) begin
            res_next = ~shifted + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            s1_mant_a_reg <= '0;
            s1_mant_b_reg <= '0;
            s1_shift_reg  <= '0;
            s1_neg_reg    <= 1'b0;
            s1_tag_reg    <= '0;
            s2_prod_reg   <= '0;
            s2_shift_reg  <= '0;
            s2_neg_reg    <= 1'b0;
            s2_tag_reg    <= '0;
            s3_r_reg      <= '0;
            s3_tag_reg    <= '0;
        end else begin
            // S1: accept and encode.
            if (s1_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (in_valid && s1_ready) begin
                s1_mant_a_reg <= mant_a;
                s1_mant_b_reg <= mant_b;
                s1_shift_reg  <= shift_sum_next;
                s1_neg_reg    <= sign_a ^ sign_b;
                s1_tag_reg    <= in_tag;
            end

            // S2: mantissa product.
            if (s2_ready) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s1_valid_reg && s2_ready) begin
                s2_prod_reg  <= prod_next;
                s2_shift_reg <= s1_shift_reg;
                s2_neg_reg   <= s1_neg_reg;
                s2_tag_reg   <= s1_tag_reg;
            end

            // S3: output register; held untouched while stalled.
            if (s3_ready) begin
                s3_valid_reg <= s2_valid_reg;
            end
            if (s2_valid_reg && s3_ready) begin
                s3_r_reg   <= res_next;
                s3_tag_reg <= s2_tag_reg;
            end
        end
    end

    assign out_valid = s3_valid_reg;
    assign r         = s3_r_reg;
    assign out_tag   = s3_tag_reg;

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Self-checking bench for drum_pipe_mult (N=M=16, KMAX=8, TW=4).
// Directed known-answer cases, backpressure, reset flush and a randomized
// stream scored against a plain-arithmetic DRUM reference model.
module tb_drum_pipe_mult;
    import drum_pkg::*;

    localparam int N    = 16;
    localparam int M    = 16;
    localparam int KMAX = 8;
    localparam int TW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [M-1:0]  b;
    logic [3:0]    k_sel;
    logic          signed_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [N+M-1:0] r;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    drum_pipe_mult #(.N(N), .M(M), .KMAX(KMAX), .TW(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .k_sel       (k_sel),
        .signed_mode (signed_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .r           (r),
        .out_tag     (out_tag)
    );

    typedef struct {
        logic [TW-1:0]  tag;
        logic [N+M-1:0] res;
        int             cyc;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            ready_mode;   // 0 = hold low, 1 = always high, 2 = random
    bit            lat_chk;
    bit            hold_pend;
    logic [N+M-1:0] hold_r;
    logic [TW-1:0] hold_tag;
    logic [TW-1:0] tag_ctr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: DRUM from its definition, using ordinary integer arithmetic.
    function automatic void encode_ref(input longint mag, input int k, output longint mant, output int sh);
        int j;
        j = 0;
        while ((mag >> (j + 1)) != 0) j++;
        if (mag < (longint'(1) << k)) begin
            mant = mag;
            sh   = 0;
        end else begin
            sh   = j - k + 1;
            mant = (mag / (longint'(1) << sh)) | 1;
        end
    endfunction

    function automatic logic [N+M-1:0] drum_ref(input logic [N-1:0] av, input logic [M-1:0] bv,
                                                input int ksel, input bit sm);
        longint va, vb, ma, mb, p;
        int     k, sa, sbs;
        k  = (ksel < KMIN) ? KMIN : ((ksel > KMAX) ? KMAX : ksel);
        va = sm ? longint'($signed(av)) : longint'(av);
        vb = sm ? longint'($signed(bv)) : longint'(bv);
        encode_ref((va < 0) ? -va : va, k, ma, sa);
        encode_ref((vb < 0) ? -vb : vb, k, mb, sbs);
        p = ma * mb * (longint'(1) << (sa + sbs));
        if (((va < 0) != (vb < 0)) && (p != 0)) p = -p;
        return p[N+M-1:0];
    endfunction

    // Output-ready generator, updated just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard compare, stall stability, latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_r", 64'(r), 64'(hold_r));
                check("hold_tag", 64'(out_tag), 64'(hold_tag));
                hold_pend = 1'b0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] retire tag=%0d r=%0d expected=%0d", out_tag, r, e.res);
                        check("result", 64'(r), 64'(e.res));
                        check("tag_order", 64'(out_tag), 64'(e.tag));
                        if (lat_chk) check("latency", 64'(cyc), 64'(e.cyc + LAT - 1));
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_r    = r;
                    hold_tag  = out_tag;
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] av, input logic [M-1:0] bv, input logic [3:0] ks,
                        input bit sm, input logic [N+M-1:0] exp);
        int   waited;
        bit   acc;
        exp_t e;
        a = av; b = bv; k_sel = ks; signed_mode = sm; in_tag = tag_ctr;
        in_valid = 1'b1;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            waited++;
        end
        if (acc) begin
            e.tag = in_tag; e.res = exp; e.cyc = cyc;
            sb.push_back(e);
            tag_ctr++;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [N-1:0] av;
        logic [M-1:0] bv;
        logic [3:0]   ks;
        bit           sm;
        av = N'($urandom);
        bv = M'($urandom);
        if ($urandom_range(0, 7) == 0) av = 16'h8000;
        if ($urandom_range(0, 7) == 0) bv = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
        ks = 4'($urandom_range(0, 15));
        sm = 1'($urandom_range(0, 1));
        send(av, bv, ks, sm, drum_ref(av, bv, int'(ks), sm));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        bit acc;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; k_sel = '0;
        signed_mode = 1'b0; in_tag = '0;
        ready_mode = 1; lat_chk = 1'b0; hold_pend = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Known answers.
        lat_chk = 1'b1;
        send(16'd1000, 16'd1000, 4'd6, 1'b0, 32'd1016064);
        send(16'd1000, 16'd1000, 4'd8, 1'b0, 32'd1008016);
        send(16'd1000, 16'd1000, 4'd2, 1'b0, 32'd802816);
        send(16'd13,   16'd11,   4'd6, 1'b0, 32'd143);
        send(16'd0,    16'd1000, 4'd6, 1'b0, 32'd0);
        send(16'(-1000), 16'd1000,   4'd6, 1'b1, 32'(-1016064));
        send(16'(-1000), 16'(-1000), 4'd6, 1'b1, 32'd1016064);
        drain();

        // Ten back-to-back; exact latency checked on every result.
        for (int i = 0; i < 10; i++) send_rand();
        drain();
        lat_chk = 1'b0;

        // Backpressure: only three fit, then everything drains in order.
        ready_mode = 0;
        @(posedge clk);
        #2;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            a = N'($urandom); b = M'($urandom); k_sel = 4'($urandom_range(0, 15));
            signed_mode = 1'($urandom_range(0, 1)); in_tag = tag_ctr;
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) begin
                e.tag = in_tag; e.res = drum_ref(a, b, int'(k_sel), signed_mode); e.cyc = cyc;
                sb.push_back(e);
                tag_ctr++;
                n_acc++;
            end
        end
        in_valid = 1'b0;
        check("stall_accepts", 64'(n_acc), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        ready_mode = 1;
        drain();

        // Reset with two transactions in flight.
        send(16'd1234, 16'd567, 4'd5, 1'b0, drum_ref(16'd1234, 16'd567, 5, 1'b0));
        send(16'd4321, 16'd765, 4'd7, 1'b0, drum_ref(16'd4321, 16'd765, 7, 1'b0));
        rst = 1'b1;
        sb.delete();
        hold_pend = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_r", 64'(r), 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #2;
        check("midrst_no_output", 64'(out_valid), 64'd0);

        // Randomized stream with random gaps and random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #2;
            end
            send_rand();
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
